col_parity_ctrl: RTL and testbench

- Sequencer for the column-parity (theta) datapath of the encoder.
- Walks the 5x5xDEPTH state memory slice by slice and drives the row-select of the 5:1 row mux and the accumulator/parity-buffer strobes.
- Then runs a second pass that writes each transformed slice back, driving the 2:1 output-mux select.
- Sits between the encoder top-level FSM (start/done) and the colParity datapath plus state memory.

---
 rtl/col_parity_ctrl.sv | 135 +++++++++++++
 tb/tb_col_parity_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/col_parity_ctrl.sv
// col_parity_ctrl: sequencer for the column-parity (theta) datapath.
// Phase 1 accumulates row parity for every slice into the parity buffer.
// Phase 2 reads each slice back and writes the transformed slice.
// Optional macro COL_PARITY_ABORT_EN adds the abort input and aborted output.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      begins one pass, sampled only in IDLE
//   busy/done  busy outside IDLE, one-cycle done pulse at the end of a pass
//   mem_*      slice address plus read/write strobes to state memory
//   row_sel    5:1 row mux select, always 0..4
//   acc_*      accumulator enable and load (clear) strobe
//   par_*      parity buffer write strobe and index
//   out_sel    output mux select, 1 = transformed slice
//   abort      (optional) abandons a pass in progress
//   aborted    (optional) one-cycle pulse after an abort
module col_parity_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef COL_PARITY_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        row_sel,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              par_wr,
  output logic [ADDR_W-1:0] par_addr,
  output logic              out_sel
);

  typedef enum logic [2:0] {
    IDLE, P_READ, P_ACC, P_STORE, A_READ, A_WRITE, DONE_S
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] z;
  logic [2:0]        row;
  logic              abort_hit;

`ifdef COL_PARITY_ABORT_EN
  assign abort_hit = abort && (state != IDLE) && (state != DONE_S);

  always_ff @(posedge clk) begin
    if (rst) aborted <= 1'b0;
    else     aborted <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || abort_hit) begin
      state <= IDLE;
      z     <= '0;
      row   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= P_READ;
            z     <= '0;
          end
        end
        P_READ: begin
          state <= P_ACC;
          row   <= '0;
        end
        P_ACC: begin
          if (row == 3'd4) begin
            row   <= '0;
            state <= P_STORE;
          end else begin
            row <= row + 3'd1;
          end
        end
        P_STORE: begin
          if (z == LAST) begin
            z     <= '0;
            state <= A_READ;
          end else begin
            z     <= z + ADDR_W'(1);
            state <= P_READ;
          end
        end
        A_READ: state <= A_WRITE;
        A_WRITE: begin
          if (z == LAST) begin
            z     <= '0;
            state <= DONE_S;
          end else begin
            z     <= z + ADDR_W'(1);
            state <= A_READ;
          end
        end
        DONE_S:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; start never reaches them.
  logic in_mem;
  logic in_par;

  assign in_mem = (state == P_READ) || (state == P_ACC) ||
                  (state == P_STORE) || (state == A_READ) ||
                  (state == A_WRITE);
  assign in_par = (state == P_STORE) || (state == A_READ) ||
                  (state == A_WRITE);

  assign busy     = (state != IDLE);
  assign done     = (state == DONE_S);
  assign mem_addr = in_mem ? z : '0;
  assign mem_rd   = (state == P_READ) || (state == A_READ);
  assign mem_wr   = (state == A_WRITE);
  assign row_sel  = (state == P_ACC) ? row : 3'd0;
  assign acc_en   = (state == P_ACC);
  assign acc_clr  = (state == P_ACC) && (row == 3'd0);
  assign par_wr   = (state == P_STORE);
  assign par_addr = in_par ? z : '0;
  assign out_sel  = (state == A_WRITE);

endmodule

// File: tb/tb_col_parity_ctrl.sv
// tb_col_parity_ctrl: self-checking bench for col_parity_ctrl, DEPTH=4.
// Expected outputs come from a per-cycle trace of one pass built from the rules.
module tb_col_parity_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int PLEN  = 9 * DEPTH + 1;
`ifdef COL_PARITY_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr, par_addr;
  logic [2:0]    row_sel;
  logic          acc_en, acc_clr, par_wr, out_sel;
`ifdef COL_PARITY_ABORT_EN
  logic          abort, aborted;
`endif

  col_parity_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef COL_PARITY_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .row_sel(row_sel),
    .acc_en(acc_en), .acc_clr(acc_clr), .par_wr(par_wr),
    .par_addr(par_addr), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [2:0]    row_sel;
    logic          acc_en;
    logic          acc_clr;
    logic          par_wr;
    logic [AW-1:0] par_addr;
    logic          out_sel;
  } obs_t;

  obs_t tr_e[$];
  obs_t tr_m[$];
  obs_t exp_o, msk;
  logic exp_ab;
  int   pos = -1;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.mem_addr = mem_addr;
    o.mem_rd = mem_rd; o.mem_wr = mem_wr; o.row_sel = row_sel;
    o.acc_en = acc_en; o.acc_clr = acc_clr; o.par_wr = par_wr;
    o.par_addr = par_addr; o.out_sel = out_sel;
    return o;
  endfunction

  function automatic void push(obs_t e, obs_t m);
    tr_e.push_back(e);
    tr_m.push_back(m);
  endfunction

  // One pass as a list of per-cycle outputs; mask clears unspecified fields.
  function automatic void build_trace();
    obs_t e, m;
    for (int z = 0; z < DEPTH; z++) begin
      e = '0; m = '1; m.par_addr = '0;
      e.busy = 1; e.mem_rd = 1; e.mem_addr = AW'(z);
      push(e, m);
      for (int r = 0; r < 5; r++) begin
        e = '0;
        e.busy = 1; e.mem_addr = AW'(z); e.row_sel = 3'(r);
        e.acc_en = 1; e.acc_clr = (r == 0);
        push(e, m);
      end
      e = '0; m = '1; m.mem_addr = '0;
      e.busy = 1; e.par_wr = 1; e.par_addr = AW'(z);
      push(e, m);
    end
    for (int z = 0; z < DEPTH; z++) begin
      e = '0; m = '1;
      e.busy = 1; e.mem_rd = 1; e.mem_addr = AW'(z); e.par_addr = AW'(z);
      push(e, m);
      e.mem_rd = 0; e.mem_wr = 1; e.out_sel = 1;
      push(e, m);
    end
    e = '0; m = '1; m.mem_addr = '0; m.par_addr = '0;
    e.busy = 1; e.done = 1;
    push(e, m);
  endfunction

  // pos = -1 means idle, otherwise index into the pass trace.
  function automatic void model_step(logic s, logic r, logic a);
    exp_ab = 1'b0;
    if (r) pos = -1;
    else if (pos < 0) begin
      if (s) pos = 0;
    end else if (a && ABORT_EN && pos != PLEN - 1) begin
      pos = -1;
      exp_ab = 1'b1;
    end else begin
      pos++;
      if (pos == PLEN) pos = -1;
    end
    if (pos < 0) begin
      exp_o = '0; msk = '1;
    end else begin
      exp_o = tr_e[pos]; msk = tr_m[pos];
    end
  endfunction

  task automatic tick(input logic s, input logic r, input logic a);
    start = s;
    rst   = r;
`ifdef COL_PARITY_ABORT_EN
    abort = a;
`endif
    @(posedge clk);
    model_step(s, r, a);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n_chk++;
      if ((sample() & msk) !== (exp_o & msk)) begin
        n_fail++;
        $display("FAIL reset c%0d got %h want %h", i, sample(), exp_o);
      end
`ifdef COL_PARITY_ABORT_EN
      n_chk++;
      if (aborted !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_aborted got %b want 0", aborted);
      end
`endif
    end
  endtask

  task automatic test_single_pass();
    int busy_n = 0, done_n = 0, done_at = 0;
    int rd_n = 0, wr_n = 0, pw_n = 0;
    int pq[$];
    int aq[$];
    for (int i = 1; i <= PLEN + 2; i++) begin
      tick(i == 1, 1'b0, 1'b0);
      n_chk++;
      if ((sample() & msk) !== (exp_o & msk)) begin
        n_fail++;
        $display("FAIL pass c%0d got %h want %h",
                 i, sample() & msk, exp_o & msk);
      end
      n_chk++;
      if ((mem_rd && mem_wr) || (par_wr && mem_wr) || (out_sel !== mem_wr)) begin
        n_fail++;
        $display("FAIL overlap c%0d rd=%b wr=%b pw=%b os=%b want exclusive",
                 i, mem_rd, mem_wr, par_wr, out_sel);
      end
      busy_n += int'(busy);
      rd_n   += int'(mem_rd);
      wr_n   += int'(mem_wr);
      pw_n   += int'(par_wr);
      if (done) begin done_n++; done_at = i; end
      if (par_wr) pq.push_back(int'(par_addr));
      if (i > 7 * DEPTH && (mem_rd || mem_wr)) aq.push_back(int'(mem_addr));
    end
    n_chk++;
    if (busy_n != PLEN) begin
      n_fail++; $display("FAIL busy_cycles got %0d want %0d", busy_n, PLEN);
    end
    n_chk++;
    if (done_n != 1 || done_at != PLEN) begin
      n_fail++;
      $display("FAIL done_pulse got n=%0d at=%0d want n=1 at=%0d",
               done_n, done_at, PLEN);
    end
    n_chk++;
    if (rd_n != 2 * DEPTH || wr_n != DEPTH || pw_n != DEPTH) begin
      n_fail++;
      $display("FAIL strobe_counts got rd=%0d wr=%0d pw=%0d want %0d %0d %0d",
               rd_n, wr_n, pw_n, 2 * DEPTH, DEPTH, DEPTH);
    end
    n_chk++;
    if (pq.size() != DEPTH) begin
      n_fail++; $display("FAIL par_seq_len got %0d want %0d", pq.size(), DEPTH);
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        n_chk++;
        if (pq[k] != k) begin
          n_fail++; $display("FAIL par_seq[%0d] got %0d want %0d", k, pq[k], k);
        end
      end
    end
    n_chk++;
    if (aq.size() != 2 * DEPTH) begin
      n_fail++; $display("FAIL ph2_len got %0d want %0d", aq.size(), 2 * DEPTH);
    end else begin
      for (int k = 0; k < 2 * DEPTH; k++) begin
        n_chk++;
        if (aq[k] != k / 2) begin
          n_fail++; $display("FAIL ph2_addr[%0d] got %0d want %0d", k, aq[k], k / 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_n = 0;
    for (int i = 1; i <= 2 * (PLEN + 1) + 4; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_chk++;
      if ((sample() & msk) !== (exp_o & msk)) begin
        n_fail++;
        $display("FAIL b2b c%0d got %h want %h", i, sample() & msk, exp_o & msk);
      end
      done_n += int'(done);
    end
    n_chk++;
    if (done_n != 2) begin
      n_fail++; $display("FAIL b2b_done got %0d want 2", done_n);
    end
  endtask

  task automatic test_reset_mid();
    int done_at = 0;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_chk++;
      if ((sample() & msk) !== (exp_o & msk)) begin
        n_fail++;
        $display("FAIL rmid c%0d got %h want %h", i, sample() & msk, exp_o & msk);
      end
    end
    tick(1'b0, 1'b1, 1'b0);
    n_chk++;
    if (sample() !== obs_t'(0)) begin
      n_fail++; $display("FAIL rmid_clear got %h want 0", sample());
    end
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= PLEN + 10 && done_at == 0; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_chk++;
      if ((sample() & msk) !== (exp_o & msk)) begin
        n_fail++;
        $display("FAIL rmid2 c%0d got %h want %h", i, sample() & msk, exp_o & msk);
      end
      if (done) done_at = i;
    end
    n_chk++;
    if (done_at != PLEN) begin
      n_fail++; $display("FAIL rmid_latency got %0d want %0d", done_at, PLEN);
    end
  endtask

`ifdef COL_PARITY_ABORT_EN
  task automatic test_abort();
    int done_n = 0;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 30; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    n_chk++;
    if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mid got ab=%b busy=%b done=%b want 1 0 0",
               aborted, busy, done);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (aborted !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_after got ab=%b done=%b busy=%b want 0",
                 aborted, done, busy);
      end
    end
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= PLEN; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      done_n += int'(done);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_chk++;
    if (done_n != 1 || aborted !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done got done_n=%0d ab=%b busy=%b want 1 0 0",
               done_n, aborted, busy);
    end
    tick(1'b1, 1'b0, 1'b1);
    n_chk++;
    if (busy !== 1'b1 || aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle_start got busy=%b ab=%b want 1 0", busy, aborted);
    end
    tick(1'b0, 1'b1, 1'b1);
    n_chk++;
    if (busy !== 1'b0 || aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rst got busy=%b ab=%b want 0 0", busy, aborted);
    end
  endtask
`endif

  task automatic test_random();
    logic s, r, a;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 99) == 0);
      a = ABORT_EN && ($urandom_range(0, 39) == 0);
      tick(s, r, a);
      n_chk++;
      if ((sample() & msk) !== (exp_o & msk)) begin
        n_fail++;
        $display("FAIL rand c%0d got %h want %h", i, sample() & msk, exp_o & msk);
      end
`ifdef COL_PARITY_ABORT_EN
      n_chk++;
      if (aborted !== exp_ab) begin
        n_fail++;
        $display("FAIL rand_aborted c%0d got %b want %b", i, aborted, exp_ab);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
`ifdef COL_PARITY_ABORT_EN
    abort = 1'b0;
`endif
    build_trace();
    @(negedge clk);
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_reset_mid();
`ifdef COL_PARITY_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
